// File: rtl/ah_addr_map_pkg.sv
// Address-map constants and types shared by the AH range encoder and its matching decoder.
package ah_addr_map_pkg;

    localparam int NUM_CLIENTS = 30;
    localparam int FIELD_W     = 57;
    localparam int SEL_W       = 5;
    localparam int OFFSET_W    = 16;

    typedef logic [SEL_W-1:0]    client_idx_t;
    typedef logic [FIELD_W-1:0]  pkt_field_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    localparam pkt_field_t RANGE_SIZE = 57'h1000;
    localparam pkt_field_t BASE_ADDR  = 57'h0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } enc_state_t;

    // Index k+n reduced modulo NUM_CLIENTS; n is always below NUM_CLIENTS here.
    function automatic client_idx_t wrap_add(input client_idx_t base, input int n);
        int sum;
        sum = int'(base) + n;
        if (sum >= NUM_CLIENTS) sum = sum - NUM_CLIENTS;
        return client_idx_t'(sum);
    endfunction

endpackage

// File: rtl/ah_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer; the pointer moves past the winner on advance.
module ah_rr_arbiter
    import ah_addr_map_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   advance,
    output logic [NUM_CLIENTS-1:0] grant,
    output client_idx_t            grant_idx,
    output logic                   grant_any
);

    client_idx_t ptr_reg;
    client_idx_t ptr_next;

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!grant_any && req[wrap_add(ptr_reg, i)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_add(ptr_reg, i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_idx == client_idx_t'(gi));
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (advance && grant_any) ptr_next = wrap_add(grant_idx, 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_reg <= '0;
        else     ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/ah_range_encoder.sv
// Arbitrates client requests and encodes the winner's offset into its absolute decode window.
// Define AH_ENC_ERR_CNT_EN to add a saturating 16-bit count of dropped out-of-window requests.
module ah_range_encoder
    import ah_addr_map_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          req_valid,
    input  logic [NUM_CLIENTS*OFFSET_W-1:0] req_offset,
    output logic [NUM_CLIENTS-1:0]          req_ready,
    output logic                            egress_valid,
    input  logic                            egress_ready,
    output pkt_field_t                      egress_pkt_field,
    output client_idx_t                     egress_client,
`ifdef AH_ENC_ERR_CNT_EN
    output logic [15:0]                     err_cnt,
`endif
    output logic                            enc_err
);

    localparam int SEL_DEPTH = 2**SEL_W;

    enc_state_t             state_reg, state_next;
    logic                   load;
    logic [NUM_CLIENTS-1:0] grant;
    client_idx_t            grant_idx;
    logic                   grant_any;
    logic                   offset_ok;
    logic                   valid_grant;
    logic                   enc_err_next;
    offset_t                sel_offset;
    pkt_field_t             field_next;
    pkt_field_t             field_reg;
    client_idx_t            client_reg;
    logic                   enc_err_reg;
    offset_t                offset_arr [SEL_DEPTH];

    // Padded to a power of two so any grant_idx value indexes a defined entry.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_DEPTH; gi++) begin : g_offset
            if (gi < NUM_CLIENTS) begin : g_live
                assign offset_arr[gi] = req_offset[gi*OFFSET_W +: OFFSET_W];
            end else begin : g_pad
                assign offset_arr[gi] = '0;
            end
        end
    endgenerate

    ah_rr_arbiter u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_offset   = offset_arr[grant_idx];
    assign offset_ok    = pkt_field_t'(sel_offset) < RANGE_SIZE;
    assign valid_grant  = grant_any && offset_ok;
    assign enc_err_next = load && grant_any && !offset_ok;
    assign field_next   = BASE_ADDR + pkt_field_t'(grant_idx) * RANGE_SIZE + pkt_field_t'(sel_offset);
    assign req_ready    = load ? grant : '0;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (valid_grant) state_next = ST_BUSY;
            ST_BUSY: if (egress_ready) state_next = valid_grant ? ST_BUSY : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs; a stalled beat blocks all new grants
    always_comb begin
        egress_valid = (state_reg == ST_BUSY);
        load         = !egress_valid || egress_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_reg   <= '0;
            client_reg  <= '0;
            enc_err_reg <= 1'b0;
        end else begin
            enc_err_reg <= enc_err_next;
            if (load && valid_grant) begin
                field_reg  <= field_next;
                client_reg <= grant_idx;
            end
        end
    end

    assign egress_pkt_field = field_reg;
    assign egress_client    = client_reg;
    assign enc_err          = enc_err_reg;

`ifdef AH_ENC_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    // Counts on the same edge that raises enc_err, so the two agree in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    err_cnt_reg <= '0;
        else if (enc_err_next && err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule
